// File: rtl/control_pkg.sv
// control_pkg: shared FSM states, frame layout constants and frame builder for control
package control_pkg;
  typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;
  localparam int FRAME_BITS = 18;
  localparam logic RW_WRITE = 1'b0;
  localparam logic ACK_REL = 1'b1;
  function automatic logic [FRAME_BITS-1:0] frame(input logic [6:0] addr, input logic [7:0] data);
    return {addr, RW_WRITE, ACK_REL, data, ACK_REL};
  endfunction
endpackage

// File: rtl/button_press.sv
// button_press: 2-FF synchroniser plus one-shot press event for an active-low button
// Ports: clk, rst_n (sync, active-low), bbutton (async active-low button), press (1-clock registered pulse)
// CONTROL_DEBOUNCE_EN: when defined, press fires only after DEBOUNCE_CYCLES consecutive low samples
module button_press #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bbutton,
  output logic press
);
  logic s1, s2, armed, fire;
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
`ifdef CONTROL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] cnt;
  // fires on the edge that brings the stable-low count up to DEBOUNCE_CYCLES
  assign fire = armed && !s2 && cnt == LAST;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else cnt <= s2 ? '0 : (cnt != FULL ? cnt + 1'b1 : cnt);
  end
`else
  assign fire = armed && !s2;
`endif
  // armed drops after one event and only returns once the button is seen high again
  always_ff @(posedge clk) begin
    if (!rst_n) {s1, s2, armed, press} <= 4'b1110;
    else begin
      s1 <= bbutton;
      s2 <= s1;
      armed <= s2 || (armed && !fire);
      press <= fire;
    end
  end
endmodule

// File: rtl/control.sv
// control: button-triggered I2C-style write frame generator (START, addr+W, ACK, data counter, ACK, STOP)
// Ports: clk, rst_n (sync, active-low), bbutton (async active-low button), sck/sda (registered, idle high)
// CONTROL_DEBOUNCE_EN: enables the press debounce inside button_press
module control
  import control_pkg::*;
#(
  parameter int HALF_DIV = 4,
  parameter logic [6:0] ADDR = 7'h3C,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bbutton,
  output logic sck,
  output logic sda
);
  localparam int DW = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;
  localparam logic [DW-1:0] DLAST = DW'(HALF_DIV - 1);
  localparam logic [4:0] ILAST = 5'(FRAME_BITS - 1);
  if (HALF_DIV < 1) begin : g_bad_cfg
    $error("HALF_DIV must be at least 1");
  end
  state_t state, state_n;
  logic [DW-1:0] div, div_n;
  logic [4:0] idx, idx_n;
  logic [FRAME_BITS-1:0] sh, sh_n;
  logic [7:0] data, data_n;
  logic ph, ph_n, sck_n, sda_n, press, last;
  button_press #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_press (
    .clk(clk),
    .rst_n(rst_n),
    .bbutton(bbutton),
    .press(press)
  );
  assign last = div == DLAST;
  // outputs are computed alongside the next state so sck/sda leave flops in step with the FSM
  always_comb begin
    state_n = state;
    div_n = last ? '0 : div + 1'b1;
    ph_n = ph;
    idx_n = idx;
    sh_n = sh;
    data_n = data;
    sck_n = sck;
    sda_n = sda;
    case (state)
      IDLE: begin
        div_n = '0;
        if (press) begin
          state_n = START;
          sh_n = frame(ADDR, data);
          sck_n = 1'b1;
          sda_n = 1'b0;
        end
      end
      START: if (last) begin
        state_n = BITS;
        ph_n = 1'b0;
        idx_n = '0;
        sck_n = 1'b0;
        sda_n = sh[FRAME_BITS-1];
      end
      BITS: if (last) begin
        if (!ph) begin
          ph_n = 1'b1;
          sck_n = 1'b1;
        end else if (idx == ILAST) begin
          state_n = STOP;
          ph_n = 1'b0;
          sck_n = 1'b0;
          sda_n = 1'b0;
        end else begin
          ph_n = 1'b0;
          idx_n = idx + 1'b1;
          sh_n = sh << 1;
          sck_n = 1'b0;
          sda_n = sh[FRAME_BITS-2];
        end
      end
      STOP: if (last) begin
        if (!ph) begin
          ph_n = 1'b1;
          sck_n = 1'b1;
        end else begin
          state_n = IDLE;
          ph_n = 1'b0;
          sda_n = 1'b1;
          data_n = data + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      div <= '0;
      ph <= 1'b0;
      idx <= '0;
      sh <= '0;
      data <= '0;
      sck <= 1'b1;
      sda <= 1'b1;
    end else begin
      state <= state_n;
      div <= div_n;
      ph <= ph_n;
      idx <= idx_n;
      sh <= sh_n;
      data <= data_n;
      sck <= sck_n;
      sda <= sda_n;
    end
  end
endmodule

// File: tb/tb_control.sv
// tb_control: directed self-checking bench for control (default parameters)
module tb_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bbutton = 1'b1;
  logic sck, sda;
  int checks = 0;
  int passed = 0;
`ifdef CONTROL_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  localparam int LAT = DEB ? 18 : 3;
  localparam int FRAME_LEN = 156;

  control dut (
    .clk(clk),
    .rst_n(rst_n),
    .bbutton(bbutton),
    .sck(sck),
    .sda(sda)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    bbutton = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    bbutton = 1'b1;
  endtask

  task automatic wait_start(input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget && lat < 0; n++) begin
      tick();
      if (sda === 1'b0) lat = n - 1;
    end
  endtask

  // decode from just after the START fall until sda rises with sck high
  task automatic read_frame(output logic [18:0] bits, output int nbits, output int len, output int viol);
    logic ps, pd;
    bit done;
    bits = '0;
    nbits = 0;
    len = 0;
    viol = 0;
    done = 1'b0;
    ps = sck;
    pd = sda;
    while (!done && len < 400) begin
      tick();
      len++;
      if (!ps && sck === 1'b1) begin
        bits = {bits[17:0], sda};
        nbits++;
      end
      if (ps && sck === 1'b1 && pd === 1'b0 && sda === 1'b1) done = 1'b1;
      else if (ps && sck === 1'b1 && sda !== pd) viol++;
      ps = sck;
      pd = sda;
    end
  endtask

  task automatic do_frame(input string name, input int hold, input logic [7:0] exp_data);
    int lat, nbits, len, viol;
    logic [18:0] bits;
    fork pulse(hold); join_none
    wait_start(300, lat);
    read_frame(bits, nbits, len, viol);
    checks++; if (lat !== LAT) $display("FAIL %s latency: got %0d want %0d", name, lat, LAT); else passed++;
    checks++; if (nbits !== 19) $display("FAIL %s sck_rises: got %0d want 19", name, nbits); else passed++;
    checks++; if (bits[18:12] !== 7'h3C) $display("FAIL %s addr: got %h want 3c", name, bits[18:12]); else passed++;
    checks++; if (bits[11:10] !== 2'b01) $display("FAIL %s rw_ack: got %b want 01", name, bits[11:10]); else passed++;
    checks++; if (bits[9:2] !== exp_data) $display("FAIL %s data: got %h want %h", name, bits[9:2], exp_data); else passed++;
    checks++; if (bits[1:0] !== 2'b10) $display("FAIL %s ack_stop: got %b want 10", name, bits[1:0]); else passed++;
    checks++; if (len !== FRAME_LEN) $display("FAIL %s frame_len: got %0d want %0d", name, len, FRAME_LEN); else passed++;
    checks++; if (viol !== 0) $display("FAIL %s sda_change_while_sck_high: got %0d want 0", name, viol); else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (sck !== 1'b1) $display("FAIL reset_sck: got %b want 1", sck); else passed++;
    checks++; if (sda !== 1'b1) $display("FAIL reset_sda: got %b want 1", sda); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    int bad = 0;
    repeat (100) begin
      tick();
      if (sck !== 1'b1 || sda !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL idle_outputs: got %0d non-idle samples want 0", bad); else passed++;
  endtask

  task automatic test_first_frame();
    do_frame("frame0", 25, 8'h00);
    repeat (10) tick();
  endtask

  task automatic test_second_frame();
    do_frame("frame1", 25, 8'h01);
    repeat (10) tick();
  endtask

  task automatic test_busy_press();
    int lat;
    fork
      begin
        repeat (30) @(posedge clk);
        #1;
        pulse(25);
      end
    join_none
    do_frame("frame_busy", 25, 8'h02);
    wait_start(200, lat);
    checks++; if (lat !== -1) $display("FAIL busy_no_extra_frame: got start at %0d want none", lat); else passed++;
    do_frame("frame_after_busy", 25, 8'h03);
    repeat (10) tick();
  endtask

  task automatic test_reset_mid_frame();
    int lat;
    fork pulse(25); join_none
    wait_start(300, lat);
    repeat (30) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (sck !== 1'b1) $display("FAIL midreset_sck: got %b want 1", sck); else passed++;
    checks++; if (sda !== 1'b1) $display("FAIL midreset_sda: got %b want 1", sda); else passed++;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    do_frame("frame_after_reset", 25, 8'h00);
    repeat (10) tick();
  endtask

  task automatic test_short_pulse();
    int lat, nbits, len, viol;
    logic [18:0] bits;
    int exp_lat;
    exp_lat = DEB ? -1 : 3;
    fork pulse(10); join_none
    wait_start(200, lat);
    checks++; if (lat !== exp_lat) $display("FAIL short_pulse_latency: got %0d want %0d", lat, exp_lat); else passed++;
    if (lat >= 0) begin
      read_frame(bits, nbits, len, viol);
      checks++; if (bits[9:2] !== 8'h01) $display("FAIL short_pulse_data: got %h want 01", bits[9:2]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_first_frame();
    test_second_frame();
    test_busy_press();
    test_reset_mid_frame();
    test_short_pulse();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
